rst_seq: RTL and testbench

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_seq.sv | 121 ++++++++++++
 tb/tb_rst_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
// Staged reset sequencer: releases STAGES reset domains one per HOLD_CYCLES,
// and re-asserts them one per cycle (highest first) on a soft-reset request.
module rst_seq #(
  parameter int STAGES      = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_rst_req,
  output logic [STAGES-1:0] rst_out,
  output logic              ready,
  output logic              busy
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam int IW = $clog2(STAGES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(STAGES - 1);

  typedef enum logic [1:0] {ASSERT, RELEASE, DONE, DRAIN} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [STAGES-1:0] sel;
  logic              hold_done;

  // One-hot of the stage index; avoids a variable bit-select wider than rst_out.
  always_comb begin
    sel = '0;
    for (int i = 0; i < STAGES; i++) sel[i] = (idx == IW'(i));
  end

  assign hold_done = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ASSERT;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
      busy    <= 1'b1;
    end else begin
      case (state)
        ASSERT: begin
          if (ext_rst_req) begin
            cnt     <= '0;
            rst_out <= '1;
          end else if (hold_done) begin
            cnt        <= '0;
            idx        <= IW'(1);
            rst_out[0] <= 1'b0;
            if (STAGES == 1) begin
              state <= DONE;
              ready <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (ext_rst_req) begin
            state   <= ASSERT;
            cnt     <= '0;
            idx     <= '0;
            rst_out <= '1;
          end else if (hold_done) begin
            cnt     <= '0;
            idx     <= idx + 1'b1;
            rst_out <= rst_out & ~sel;
            if (idx == IDX_LAST) begin
              state <= DONE;
              ready <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (ext_rst_req) begin
            ready <= 1'b0;
            busy  <= 1'b1;
            // A single domain has nothing to drain; go straight back to ASSERT.
            if (STAGES == 1) begin
              state   <= ASSERT;
              cnt     <= '0;
              idx     <= '0;
              rst_out <= '1;
            end else begin
              state               <= DRAIN;
              idx                 <= IDX_LAST;
              rst_out[STAGES-1]   <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // idx names the lowest bit already set; set the one below it.
          cnt     <= '0;
          idx     <= idx - 1'b1;
          rst_out <= rst_out | (sel >> 1);
          if (idx == IW'(1)) begin
            state <= ASSERT;
            idx   <= '0;
          end
        end
        default: begin
          state   <= ASSERT;
          cnt     <= '0;
          idx     <= '0;
          rst_out <= '1;
          ready   <= 1'b0;
          busy    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: three parameterisations driven by directed then random
// stimulus, checked every cycle against a time-since-start model.
module tb_rst_seq;
  logic       clk;
  logic [2:0] rst_v;
  logic [2:0] req_v;
  logic [3:0] ro_a;
  logic [0:0] ro_b;
  logic [2:0] ro_c;
  logic [2:0] rdy, bsy;

  int n_tests = 0;
  int n_fail  = 0;
  int ecount  = 0;

  rst_seq #(.STAGES(4), .HOLD_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst_v[0]), .ext_rst_req(req_v[0]),
    .rst_out(ro_a), .ready(rdy[0]), .busy(bsy[0]));
  rst_seq #(.STAGES(1), .HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst_v[1]), .ext_rst_req(req_v[1]),
    .rst_out(ro_b), .ready(rdy[1]), .busy(bsy[1]));
  rst_seq #(.STAGES(3), .HOLD_CYCLES(2)) dut_c (
    .clk(clk), .rst(rst_v[2]), .ext_rst_req(req_v[2]),
    .rst_out(ro_c), .ready(rdy[2]), .busy(bsy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sp(int i);
    case (i) 0: return 4; 1: return 1; default: return 3; endcase
  endfunction
  function automatic int hp(int i);
    case (i) 0: return 4; 1: return 1; default: return 2; endcase
  endfunction

  // Model: m_t = edges since the sequence (re)started; while draining,
  // m_d = number of top bits re-asserted so far.
  int m_t[3]     = '{0, 0, 0};
  int m_d[3]     = '{0, 0, 0};
  bit m_drain[3] = '{0, 0, 0};

  always @(posedge clk or rst_v) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_v[i]) begin
        m_t[i] = 0; m_d[i] = 0; m_drain[i] = 0;
      end else if (clk) begin
        if (m_drain[i]) begin
          m_d[i]++;
          if (m_d[i] == sp(i)) begin m_drain[i] = 0; m_t[i] = 0; end
        end else if (m_t[i] >= sp(i) * hp(i)) begin
          if (req_v[i]) begin
            if (sp(i) == 1) m_t[i] = 0;
            else begin m_drain[i] = 1; m_d[i] = 1; end
          end
        end else if (req_v[i]) m_t[i] = 0;
        else m_t[i]++;
      end
    end
  end

  function automatic logic [9:0] exp_out(int i);
    logic [7:0] r = '0;
    logic       rd;
    for (int k = 0; k < sp(i); k++)
      r[k] = m_drain[i] ? (k >= sp(i) - m_d[i]) : (m_t[i] < (k + 1) * hp(i));
    rd = !m_drain[i] && (m_t[i] >= sp(i) * hp(i));
    return {r, rd, !rd};
  endfunction

  function automatic logic [9:0] act_out(int i);
    case (i)
      0:       return {4'b0, ro_a, rdy[0], bsy[0]};
      1:       return {7'b0, ro_b, rdy[1], bsy[1]};
      default: return {5'b0, ro_c, rdy[2], bsy[2]};
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [9:0] e, a;
      e = exp_out(i);
      a = act_out(i);
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL model inst%0d t=%0t got rst_out=%b ready=%b busy=%b exp rst_out=%b ready=%b busy=%b",
                 i, $time, a[9:2], a[1], a[0], e[9:2], e[1], e[0]);
      end
    end
  end

  // Literal checks on {rst_out, ready, busy}
  task automatic chk(string nm, logic [5:0] got, logic [5:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got %b exp %b", nm, ecount, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ecount++;
  endtask

  task automatic run_to(int n);
    while (ecount < n) tick();
  endtask

  function automatic logic [5:0] ga();
    return {ro_a, rdy[0], bsy[0]};
  endfunction
  function automatic logic [5:0] gb();
    return {3'b0, ro_b, rdy[1], bsy[1]};
  endfunction

  int burst[3] = '{0, 0, 0};

  initial begin
    rst_v = 3'b000;
    req_v = 3'b000;
    repeat (3) @(negedge clk);
    chk("reset_a", ga(), 6'b1111_01);
    chk("reset_b", gb(), 6'b000_1_01);
    #1 rst_v = 3'b111;
    ecount = 0;
    run_to(1);  chk("b_edge1", gb(), 6'b000_0_10);
    run_to(3);  chk("pwr_e3", ga(), 6'b1111_01);
    run_to(4);  chk("pwr_e4", ga(), 6'b1110_01);
    run_to(8);  chk("pwr_e8", ga(), 6'b1100_01);
    run_to(12); chk("pwr_e12", ga(), 6'b1000_01);
    run_to(15); chk("pwr_e15", ga(), 6'b1000_01);
    run_to(16); chk("pwr_e16", ga(), 6'b0000_10);
    // soft reset from DONE, N = 20
    run_to(20); #1 req_v[0] = 1'b1;
    run_to(21); chk("soft_n1", ga(), 6'b1000_01); #1 req_v[0] = 1'b0;
    run_to(22); chk("soft_n2", ga(), 6'b1100_01);
    run_to(23); chk("soft_n3", ga(), 6'b1110_01);
    run_to(24); chk("soft_n4", ga(), 6'b1111_01);
    run_to(27); chk("soft_n7", ga(), 6'b1111_01);
    run_to(28); chk("soft_n8", ga(), 6'b1110_01);
    // restart mid-RELEASE, relative edge 10 = 34
    run_to(34); chk("rel_e34", ga(), 6'b1100_01); #1 req_v[0] = 1'b1;
    run_to(35); chk("restart", ga(), 6'b1111_01); #1 req_v[0] = 1'b0;
    run_to(38); chk("restart_hold", ga(), 6'b1111_01);
    run_to(39); chk("restart_rel0", ga(), 6'b1110_01);
    // async reset mid-DRAIN
    run_to(52); chk("done_52", ga(), 6'b0000_10); #1 req_v[0] = 1'b1;
    run_to(53); chk("drain1", ga(), 6'b1000_01); #1 req_v[0] = 1'b0;
    run_to(54); chk("drain2", ga(), 6'b1100_01);
    #1 rst_v[0] = 1'b0;
    #1 chk("async_drain", ga(), 6'b1111_01);
    run_to(56); #1 rst_v[0] = 1'b1;
    run_to(59); chk("post_rst_e3", ga(), 6'b1111_01);
    run_to(60); chk("post_rst_e4", ga(), 6'b1110_01);
    run_to(72); chk("post_rst_e16", ga(), 6'b0000_10);
    // request held high through DRAIN and beyond
    run_to(74); #1 req_v[1:0] = 2'b11;
    run_to(77); chk("held_drain3", ga(), 6'b1110_01);
    run_to(78); chk("held_drain4", ga(), 6'b1111_01);
                chk("b_held", gb(), 6'b000_1_01);
    run_to(82); chk("held_restart", ga(), 6'b1111_01); #1 req_v[1:0] = 2'b00;
    run_to(83); chk("b_rerelease", gb(), 6'b000_0_10);
    run_to(85); chk("held_rel_e3", ga(), 6'b1111_01);
    run_to(86); chk("held_rel_e4", ga(), 6'b1110_01);
    // random phase
    for (int c = 0; c < 3000; c++) begin
      tick();
      #1;
      for (int i = 0; i < 3; i++) begin
        if (!rst_v[i]) begin
          if ($urandom_range(0, 2) == 0) rst_v[i] = 1'b1;
        end else if ($urandom_range(0, 299) == 0) rst_v[i] = 1'b0;
        if (burst[i] > 0) burst[i]--;
        else if ($urandom_range(0, 63) == 0) burst[i] = $urandom_range(2, 10);
        req_v[i] = (burst[i] > 0) || ($urandom_range(0, 15) == 0);
      end
    end
    #1 begin rst_v = 3'b111; req_v = 3'b000; end
    repeat (40) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
